// File: rtl/serializador_pkg.sv
// Shared types and defaults for the parallel-in, serial-out transmitter.
package serializador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    localparam int WORD_WIDTH     = 32;
    localparam int BIT_CYCLES_DEF = 1;

    // Counter width that stays at least one bit when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: while enabled, pulses tick on the last cycle of every BIT_CYCLES-cycle period.
// tick is combinational from the divider count; clear restarts the period from zero.
module bit_tick_gen
    import serializador_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int DW = cnt_width(BIT_CYCLES);
    localparam logic [DW-1:0] LAST = DW'(BIT_CYCLES - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        tick      = 1'b0;
        if (clear) begin
            div_cnt_d = '0;
        end else if (enable) begin
            if (div_cnt_q == LAST) begin
                tick      = 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/serializador_piso.sv
// Parallel-in, serial-out transmitter: accepts a word on valid/ready and shifts it out MSB first,
// one serial_valid strobe per bit at the end of each bit period, then a one-cycle done pulse.
module serializador_piso
    import serializador_pkg::*;
#(
    parameter int WIDTH      = WORD_WIDTH,
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    bit_cnt_q;
    logic [CW-1:0]    bit_cnt_d;
    logic             accept;
    logic             in_shift;
    logic             tick;

    assign in_shift   = (state_q == SHIFT);
    assign load_ready = (state_q == IDLE) && !reset;
    assign accept     = load_valid && load_ready;

    bit_tick_gen #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (in_shift),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    // Last bit: park the counter at zero instead of letting it wrap.
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // All outputs decode flops only, so serial_out holds steady across the bit period.
    assign serial_out   = in_shift && shreg_q[WIDTH-1];
    assign serial_valid = in_shift && tick;
    assign busy         = in_shift;
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_serializador_piso.sv
// Self-checking bench: default instance plus a BIT_CYCLES=4 instance, checked against a per-cycle frame model.
module tb_serializador_piso;

    logic        clock;
    logic        reset;
    logic [31:0] data_in;
    logic        lv;
    logic        sel;

    logic lv1, lr1, so1, sv1, bz1, dn1;
    logic lv4, lr4, so4, sv4, bz4, dn4;
    logic lr, so, sv, bz, dn;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    assign lv1 = lv && !sel;
    assign lv4 = lv && sel;
    assign lr  = sel ? lr4 : lr1;
    assign so  = sel ? so4 : so1;
    assign sv  = sel ? sv4 : sv1;
    assign bz  = sel ? bz4 : bz1;
    assign dn  = sel ? dn4 : dn1;

    serializador_piso dut1 (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .load_valid   (lv1),
        .load_ready   (lr1),
        .serial_out   (so1),
        .serial_valid (sv1),
        .busy         (bz1),
        .done         (dn1)
    );

    serializador_piso #(.WIDTH(32), .BIT_CYCLES(4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .load_valid   (lv4),
        .load_ready   (lr4),
        .serial_out   (so4),
        .serial_valid (sv4),
        .busy         (bz4),
        .done         (dn4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Present a word at a falling edge; it is taken on the next rising edge.
    // Returns at the falling edge of the first bit cycle.
    task automatic accept(input logic [31:0] word, input bit keep);
        lv      = 1'b1;
        data_in = word;
        @(negedge clock);
        if (!keep) lv = 1'b0;
    endtask

    // Frame model: bit i of the frame (1-based cycle) carries word[31 - (i-1)/bc],
    // strobes when i is a multiple of bc, then one DONE cycle, then ready again.
    task automatic check_frame(input logic [31:0] word, input int bc, input string name,
                               output logic [31:0] rx);
        logic [4:0] got;
        logic [4:0] exp;
        int         bit_idx;
        rx = '0;
        for (int i = 1; i <= 32 * bc; i++) begin
            bit_idx = (i - 1) / bc;
            exp = {word[31 - bit_idx], ((i % bc) == 0), 1'b1, 1'b0, 1'b0};
            got = {so, sv, bz, lr, dn};
            chk_cnt++;
            if (got !== exp) begin
                $display("FAIL %s cycle %0d {so,sv,busy,ready,done}: got %b expected %b", name, i, got, exp);
            end else begin
                pass_cnt++;
            end
            if (sv) rx = {rx[30:0], so};
            @(negedge clock);
        end
        got = {so, sv, bz, lr, dn};
        chk_cnt++;
        if (got !== 5'b00001) begin
            $display("FAIL %s done cycle %0d: got %b expected 00001", name, 32 * bc + 1, got);
        end else begin
            pass_cnt++;
        end
        @(negedge clock);
        got = {so, sv, bz, lr, dn};
        chk_cnt++;
        if (got !== 5'b00010) begin
            $display("FAIL %s ready-return cycle: got %b expected 00010", name, got);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_rx(input string name, input logic [31:0] rx, input logic [31:0] word);
        chk_cnt++;
        if (rx !== word) begin
            $display("FAIL %s receiver word: got %h expected %h", name, rx, word);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset();
        sel     = 1'b0;
        lv      = 1'b0;
        data_in = '0;
        reset   = 1'b1;
        repeat (3) @(negedge clock);
        chk_cnt++;
        if ({lr1, so1, sv1, bz1, dn1, lr4, so4, sv4, bz4, dn4} !== 10'b0) begin
            $display("FAIL reset_outputs: got %b expected 0000000000",
                     {lr1, so1, sv1, bz1, dn1, lr4, so4, sv4, bz4, dn4});
        end else begin
            pass_cnt++;
        end
        reset = 1'b0;
        @(negedge clock);
        chk_cnt++;
        if ({lr1, bz1, dn1, lr4, bz4, dn4} !== 6'b100100) begin
            $display("FAIL idle_after_reset: got %b expected 100100", {lr1, bz1, dn1, lr4, bz4, dn4});
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_known_word();
        logic [31:0] rx;
        sel = 1'b0;
        accept(32'hA5A5_F00F, 1'b0);
        check_frame(32'hA5A5_F00F, 1, "known_a5a5", rx);
        check_rx("known_a5a5", rx, 32'hA5A5_F00F);
    endtask

    task automatic test_slow_bits();
        logic [31:0] rx;
        sel = 1'b1;
        accept(32'h8000_0000, 1'b0);
        check_frame(32'h8000_0000, 4, "slow_msb", rx);
        check_rx("slow_msb", rx, 32'h8000_0000);
        sel = 1'b0;
    endtask

    task automatic test_hold_during_frame();
        logic [31:0] rx;
        logic [31:0] w1;
        sel = 1'b0;
        w1  = $urandom;
        accept(w1, 1'b1);
        data_in = 32'h1234_5678;
        check_frame(w1, 1, "hold_first", rx);
        check_rx("hold_first", rx, w1);
        @(negedge clock);
        lv = 1'b0;
        check_frame(32'h1234_5678, 1, "hold_second", rx);
        check_rx("hold_second", rx, 32'h1234_5678);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rx;
        sel = 1'b0;
        accept(32'hFFFF_FFFF, 1'b1);
        data_in = 32'h0000_0001;
        check_frame(32'hFFFF_FFFF, 1, "b2b_ones", rx);
        check_rx("b2b_ones", rx, 32'hFFFF_FFFF);
        @(negedge clock);
        lv = 1'b0;
        check_frame(32'h0000_0001, 1, "b2b_one", rx);
        check_rx("b2b_one", rx, 32'h0000_0001);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rx;
        int          saw_done;
        sel = 1'b0;
        accept($urandom | 32'h8000_0000, 1'b0);
        repeat (9) @(negedge clock);
        chk_cnt++;
        if (sv !== 1'b1) begin
            $display("FAIL abort_tenth_strobe: got %b expected 1", sv);
        end else begin
            pass_cnt++;
        end
        reset = 1'b1;
        @(negedge clock);
        chk_cnt++;
        if ({so, sv, bz, dn, lr} !== 5'b00000) begin
            $display("FAIL abort_after_reset {so,sv,busy,done,ready}: got %b expected 00000", {so, sv, bz, dn, lr});
        end else begin
            pass_cnt++;
        end
        reset    = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (dn || bz) saw_done++;
        end
        chk_cnt++;
        if (saw_done != 0) begin
            $display("FAIL abort_no_done: got %0d done/busy cycles expected 0", saw_done);
        end else begin
            pass_cnt++;
        end
        accept(32'hDEAD_BEEF, 1'b0);
        check_frame(32'hDEAD_BEEF, 1, "after_abort", rx);
        check_rx("after_abort", rx, 32'hDEAD_BEEF);
    endtask

    task automatic test_load_during_reset();
        logic [31:0] rx;
        logic [31:0] w;
        sel     = 1'b0;
        w       = $urandom;
        reset   = 1'b1;
        lv      = 1'b1;
        data_in = w;
        #1;
        chk_cnt++;
        if (lr !== 1'b0) begin
            $display("FAIL ready_in_reset: got %b expected 0", lr);
        end else begin
            pass_cnt++;
        end
        @(negedge clock);
        chk_cnt++;
        if ({bz, lr} !== 2'b00) begin
            $display("FAIL no_accept_in_reset {busy,ready}: got %b expected 00", {bz, lr});
        end else begin
            pass_cnt++;
        end
        reset = 1'b0;
        #1;
        chk_cnt++;
        if (lr !== 1'b1) begin
            $display("FAIL ready_after_reset: got %b expected 1", lr);
        end else begin
            pass_cnt++;
        end
        @(negedge clock);
        lv = 1'b0;
        check_frame(w, 1, "load_after_reset", rx);
        check_rx("load_after_reset", rx, w);
    endtask

    task automatic test_random();
        logic [31:0] rx;
        logic [31:0] w;
        int          gap;
        for (int n = 0; n < 8; n++) begin
            sel = (n >= 6);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clock);
            w = $urandom;
            accept(w, 1'b0);
            check_frame(w, sel ? 4 : 1, sel ? "random_slow" : "random", rx);
            check_rx(sel ? "random_slow" : "random", rx, w);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_known_word();
        test_slow_bits();
        test_hold_during_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_load_during_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serializador_piso.md
Name: serializador_piso

Overview:
- Parallel-in, serial-out transmitter that produces the bit stream consumed by the team's serial-in shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first.
- Emits one enable strobe per bit, so a receiver clocked on the same clock captures the word exactly.
- Sits between the word-producing datapath and the serial link; frame completion is reported with a done pulse.

Parameters:
- WIDTH, 32, word length in bits; must be ≥ 2.
- BIT_CYCLES, 1, clock cycles per bit period; must be ≥ 1.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  transmitter can accept a word this cycle.
- serial_out  output  1  current bit on the line; MSB first.
- serial_valid  output  1  one-cycle strobe per bit; drives the receiver's enable.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last bit strobe.

Behaviour:
- Reset: reset, synchronous, active-high; clock clock.
  - Reset value of every output and internal register is 0: shreg, bit_cnt, div_cnt, serial_out, serial_valid, busy, done. load_ready is also 0 while reset is asserted. State goes to IDLE.
  - Reset asserted mid-frame aborts the frame. No done pulse is produced, and serial_out reads 0 the cycle after the reset edge.
- IDLE:
  - load_ready=1, busy=0, serial_out=0.
  - On load_valid && load_ready: shreg<=data_in, bit_cnt<=0, div_cnt<=0, go to SHIFT.
- SHIFT:
  - busy=1, load_ready=0, serial_out=shreg[WIDTH-1] (registered; stable for the whole bit period).
  - div_cnt counts 0..BIT_CYCLES-1.
  - serial_valid=1 only in the cycle where div_cnt==BIT_CYCLES-1. The strobe falls at the end of the bit period, so the receiver samples settled data.
  - On the strobe cycle: shreg<=shreg<<1 (LSB filled with 0), div_cnt<=0, bit_cnt<=bit_cnt+1.
  - If bit_cnt==WIDTH-1 on the strobe cycle, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0, load_ready=0, serial_out=0; go to IDLE.
- Latency:
  - A load accepted at edge k puts the MSB on serial_out in cycle k+1.
  - Exactly WIDTH strobes follow over WIDTH*BIT_CYCLES cycles.
  - done occurs in cycle k+WIDTH*BIT_CYCLES+1.
  - load_ready returns one cycle after done.
- Handshake and width rules:
  - load_valid while load_ready=0 is ignored and data_in is not sampled. The producer holds the word until accepted.
  - bit_cnt width is $clog2(WIDTH); div_cnt width is max(1,$clog2(BIT_CYCLES)). No wrap-around is reachable in either.
  - BIT_CYCLES=1: serial_valid is high for WIDTH consecutive cycles.
- End-to-end: after WIDTH strobes, a WIDTH-bit serial-in register fed with shift_in=serial_out and enable=serial_valid holds data_in exactly.

Decomposition:
- Shared package serializador_pkg:
  - state enum tx_state_t {IDLE, SHIFT, DONE}.
  - Default constants WORD_WIDTH=32 and BIT_CYCLES_DEF=1.
- One sub-module, bit_tick_gen:
  - Parameterized by BIT_CYCLES, with clear/enable inputs.
  - Outputs the end-of-bit-period tick that drives serial_valid and the shift.
- The rest (FSM, shift register, bit counter) stays in serializador_piso.

Test Plan:
1. Default parameters, reset, load 32'hA5A5_F00F; connect to a 32-bit serial-in register → serial_out bits per strobe 1,0,1,0,0,1,0,1,… (MSB first); receiver word==32'hA5A5_F00F after 32 strobes; done exactly 33 cycles after accept.
2. BIT_CYCLES=4, load 32'h8000_0000 → serial_out=1 for cycles 1–4, then 0; serial_valid only in cycles 4, 8, …, 128; done at cycle 129.
3. load_valid held high during a frame with data_in changed to 32'h1234_5678 → load_ready=0 throughout and the first word is unaltered; the second word is accepted on the first cycle load_ready=1 after done.
4. Back-to-back: load_valid constantly high with 32'hFFFF_FFFF then 32'h0000_0001 → exactly one non-strobe cycle (DONE) plus one IDLE cycle between frames; second frame is 31 zeros then 1.
5. Reset asserted for one cycle at the 10th strobe → next cycle serial_out=0, busy=0, serial_valid=0, no done pulse; a subsequent load of 32'hDEAD_BEEF transmits all 32 bits correctly.
6. load_valid asserted in the same cycle reset is high → word not accepted, load_ready=0; accepted in the first cycle after reset deasserts.
